// File: rtl/div_unit_pkg.sv
// Shared state encoding and default sizing for the execute-stage divider.
package div_unit_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int DIV_CNT_W_DEFAULT = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ZERO = 2'b01,
        DIV_ON   = 2'b10,
        DIV_END  = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider producing {remainder, quotient} for HI/LO.
// Operates on magnitudes and fixes up signs when the final iteration completes.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT,
    parameter int CNT_W = DIV_CNT_W_DEFAULT
)
(
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               stall_req
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    div_state_t          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [WIDTH-1:0]    r_quot;
    logic [WIDTH-1:0]    r_divisor;
    logic [WIDTH-1:0]    r_rem;
    logic                r_signed;
    logic                r_sign1;
    logic                r_sign2;
    logic [2*WIDTH-1:0]  r_result;
    logic                r_ready;

    logic [WIDTH:0]      w_shifted;
    logic [WIDTH:0]      w_trial;
    logic [WIDTH-1:0]    w_quotNext;
    logic [WIDTH-1:0]    w_remNext;
    logic [WIDTH-1:0]    w_quotFinal;
    logic [WIDTH-1:0]    w_remFinal;

    // Bit WIDTH of the trial difference doubles as its sign because rem < divisor.
    always_comb begin
        w_shifted   = {r_rem, r_quot[WIDTH-1]};
        w_trial     = w_shifted - {1'b0, r_divisor};
        w_quotNext  = {r_quot[WIDTH-2:0], ~w_trial[WIDTH]};
        w_remNext   = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_quotFinal = (r_signed && (r_sign1 ^ r_sign2)) ? -w_quotNext : w_quotNext;
        w_remFinal  = (r_signed && r_sign1) ? -w_remNext : w_remNext;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= DIV_IDLE;
            r_cnt     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_rem     <= '0;
            r_signed  <= 1'b0;
            r_sign1   <= 1'b0;
            r_sign2   <= 1'b0;
            r_result  <= '0;
            r_ready   <= 1'b0;
        end else if (annul) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    r_ready <= 1'b0;
                    if (start) begin
                        if (opdata2 == '0) begin
                            r_state <= DIV_ZERO;
                        end else begin
                            r_state   <= DIV_ON;
                            r_cnt     <= '0;
                            r_rem     <= '0;
                            r_signed  <= signed_div;
                            r_sign1   <= opdata1[WIDTH-1];
                            r_sign2   <= opdata2[WIDTH-1];
                            r_quot    <= (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
                            r_divisor <= (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
                        end
                    end
                end
                DIV_ZERO: begin
                    r_result <= '0;
                    r_state  <= DIV_END;
                end
                DIV_ON: begin
                    r_quot <= w_quotNext;
                    r_rem  <= w_remNext;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_ITER) begin
                        r_result <= {w_remFinal, w_quotFinal};
                        r_state  <= DIV_END;
                    end
                end
                DIV_END: begin
                    // The pipeline must drop start once before another divide is accepted.
                    if (start) begin
                        r_ready <= 1'b1;
                    end else begin
                        r_ready <= 1'b0;
                        r_state <= DIV_IDLE;
                    end
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    assign result    = r_result;
    assign ready     = r_ready;
    assign stall_req = start & ~r_ready & ~annul;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit: latency, signed/unsigned results, divide-by-zero,
// annul, asynchronous reset and END hold/re-arm behaviour.
module tb_div_unit;

    localparam int WIDTH = 32;

    logic               clk = 1'b0;
    logic               resetn;
    logic               start;
    logic               signed_div;
    logic [WIDTH-1:0]   opdata1;
    logic [WIDTH-1:0]   opdata2;
    logic               annul;
    logic [2*WIDTH-1:0] result;
    logic               ready;
    logic               stall_req;

    int errors = 0;
    int checks = 0;

    div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    // Launches a divide from just after an edge and waits (bounded) for ready; start stays high.
    // lat counts edges after the accepting edge; -1 means ready never arrived.
    task automatic applyStimulus(input logic sgn, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 output int lat, output bit stallOk);
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        annul      = 1'b0;
        start      = 1'b1;
        stallOk    = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        while (!ready && lat < 60) begin
            if (stall_req !== 1'b1) stallOk = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!ready) lat = -1;
    endtask

    task automatic releaseStart();
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        #3;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b expected 0", ready); end
        checks++;
        if (result !== 64'h0) begin errors++; $display("[TB] FAIL reset_result got %h expected 0", result); end
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got %b expected 0", stall_req); end
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        int lat;
        bit stallOk;
        applyStimulus(1'b0, 32'd100, 32'd7, lat, stallOk);
        checks++;
        if (lat !== 33) begin errors++; $display("[TB] FAIL divu_100_7_latency got %0d expected 33", lat); end
        checks++;
        if (result !== 64'h00000002_0000000E) begin errors++; $display("[TB] FAIL divu_100_7 got %h expected 000000020000000e", result); end
        checks++;
        if (stallOk !== 1'b1) begin errors++; $display("[TB] FAIL divu_stall_before_ready got %b expected 1", stallOk); end
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL divu_stall_at_ready got %b expected 0", stall_req); end
        releaseStart();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL divu_release_ready got %b expected 0", ready); end

        applyStimulus(1'b0, 32'hFFFFFFF9, 32'd2, lat, stallOk);
        checks++;
        if (result !== 64'h00000001_7FFFFFFC) begin errors++; $display("[TB] FAIL divu_big_2 got %h expected 000000017ffffffc", result); end
        releaseStart();

        applyStimulus(1'b0, 32'd3, 32'd10, lat, stallOk);
        checks++;
        if (result !== 64'h00000003_00000000) begin errors++; $display("[TB] FAIL divu_3_10 got %h expected 0000000300000000", result); end
        releaseStart();
    endtask

    task automatic test_signed();
        int lat;
        bit stallOk;
        applyStimulus(1'b1, 32'hFFFFFFF9, 32'd2, lat, stallOk);
        checks++;
        if (result !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("[TB] FAIL div_m7_2 got %h expected fffffffffffffffd", result); end
        checks++;
        if (lat !== 33) begin errors++; $display("[TB] FAIL div_m7_2_latency got %0d expected 33", lat); end
        releaseStart();

        applyStimulus(1'b1, 32'd7, 32'hFFFFFFFE, lat, stallOk);
        checks++;
        if (result !== 64'h00000001_FFFFFFFD) begin errors++; $display("[TB] FAIL div_7_m2 got %h expected 00000001fffffffd", result); end
        releaseStart();

        applyStimulus(1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, lat, stallOk);
        checks++;
        if (result !== 64'hFFFFFFFE_00000002) begin errors++; $display("[TB] FAIL div_m8_m3 got %h expected fffffffe00000002", result); end
        releaseStart();
    endtask

    task automatic test_div_zero();
        int lat;
        bit stallOk;
        applyStimulus(1'b0, 32'h00001234, 32'd0, lat, stallOk);
        checks++;
        if (lat !== 2) begin errors++; $display("[TB] FAIL divzero_latency got %0d expected 2", lat); end
        checks++;
        if (result !== 64'h0) begin errors++; $display("[TB] FAIL divzero_result got %h expected 0", result); end
        checks++;
        if (stallOk !== 1'b1) begin errors++; $display("[TB] FAIL divzero_stall got %b expected 1", stallOk); end
        releaseStart();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL divzero_idle_ready got %b expected 0", ready); end
    endtask

    task automatic test_overflow();
        int lat;
        bit stallOk;
        applyStimulus(1'b1, 32'h80000000, 32'hFFFFFFFF, lat, stallOk);
        checks++;
        if (lat !== 33) begin errors++; $display("[TB] FAIL overflow_latency got %0d expected 33", lat); end
        checks++;
        if (result !== 64'h00000000_80000000) begin errors++; $display("[TB] FAIL overflow_result got %h expected 0000000080000000", result); end
        releaseStart();
    endtask

    task automatic test_annul();
        int lat;
        bit stallOk;
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b0) begin errors++; $display("[TB] FAIL annul_masks_stall got %b expected 0", stall_req); end
        @(posedge clk); #1;
        annul = 1'b0;
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL annul_ready got %b expected 0", ready); end
        checks++;
        if (result !== 64'h00000000_80000000) begin errors++; $display("[TB] FAIL annul_result_held got %h expected 0000000080000000", result); end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'h00000000_80000000) begin
            errors++;
            $display("[TB] FAIL annul_stays_idle got ready=%b result=%h expected ready=0 result=0000000080000000", ready, result);
        end
        applyStimulus(1'b0, 32'd50, 32'd5, lat, stallOk);
        checks++;
        if (lat !== 33) begin errors++; $display("[TB] FAIL after_annul_latency got %0d expected 33", lat); end
        checks++;
        if (result !== 64'h00000000_0000000A) begin errors++; $display("[TB] FAIL after_annul_50_5 got %h expected 000000000000000a", result); end
        releaseStart();
    endtask

    task automatic test_reset_mid();
        signed_div = 1'b0;
        opdata1    = 32'd100;
        opdata2    = 32'd7;
        start      = 1'b1;
        @(posedge clk); #1;
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (result !== 64'h0) begin errors++; $display("[TB] FAIL async_reset_result got %h expected 0", result); end
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL async_reset_ready got %b expected 0", ready); end
        start = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'h0) begin
            errors++;
            $display("[TB] FAIL after_reset_idle got ready=%b result=%h expected ready=0 result=0", ready, result);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bit stallOk;
        bit holdOk;
        applyStimulus(1'b1, 32'hFFFFFF9C, 32'd7, lat, stallOk);
        checks++;
        if (result !== 64'hFFFFFFFE_FFFFFFF2) begin errors++; $display("[TB] FAIL div_m100_7 got %h expected fffffffefffffff2", result); end
        holdOk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            opdata1    = 32'h1000 + 32'(i);
            opdata2    = (i == 2) ? 32'd0 : 32'd3;
            signed_div = i[0];
            @(posedge clk); #1;
            if (ready !== 1'b1 || result !== 64'hFFFFFFFE_FFFFFFF2) holdOk = 1'b0;
        end
        checks++;
        if (holdOk !== 1'b1) begin errors++; $display("[TB] FAIL end_hold got ready=%b result=%h expected ready=1 result=fffffffefffffff2", ready, result); end
        releaseStart();
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL rearm_drop_ready got %b expected 0", ready); end
        applyStimulus(1'b0, 32'hFFFFFFFF, 32'h10, lat, stallOk);
        checks++;
        if (lat !== 33) begin errors++; $display("[TB] FAIL rearm_latency got %0d expected 33", lat); end
        checks++;
        if (result !== 64'h0000000F_0FFFFFFF) begin errors++; $display("[TB] FAIL rearm_result got %h expected 0000000f0fffffff", result); end
        releaseStart();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog_timeout simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_overflow();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the execute stage.
- Consumes operands plus the signed/unsigned select derived from ALU_SIGNED_DIV / ALU_UNSIGNED_DIV issued by the decode stage.
- Produces {remainder, quotient} for the HI/LO write path.
- Raises a stall request that freezes the pipeline while a division is in flight.

Parameters:
- WIDTH, 32, operand width; the result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  divide request, held high by the pipeline for as long as it stalls
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled only when start is accepted
- opdata1  in  WIDTH  dividend; sampled only when start is accepted
- opdata2  in  WIDTH  divisor; sampled only when start is accepted
- annul  in  1  flush/exception cancel; highest priority
- result  out  2*WIDTH  {remainder[63:32] -> HI, quotient[31:0] -> LO}
- ready  out  1  result valid
- stall_req  out  1  pipeline stall request

Behaviour:
- Reset (resetn=0, asynchronous):
  - state=IDLE, counter=0, result=0, ready=0.
  - Internal dividend/divisor/partial-remainder registers are cleared.
- States: IDLE, DIV_ZERO, ON, END. Encoding is 2 bits.
- IDLE:
  - If start=1 and annul=0 and opdata2==0: go to DIV_ZERO.
  - If start=1 and annul=0 and opdata2!=0: go to ON.
    - Latch the signs of opdata1 and opdata2 and the value of signed_div.
    - Latch |opdata1| and |opdata2| when signed_div=1, otherwise the raw operands.
    - Clear the partial remainder; counter=0.
  - Otherwise stay in IDLE.
- ON:
  - One restoring iteration per cycle: shift {rem, quot} left by 1 and compute trial = rem - divisor using WIDTH+1 bits.
  - If trial is non-negative: rem=trial and the quotient LSB is 1; otherwise the quotient LSB is 0.
  - counter increments each cycle.
  - On the 32nd iteration edge (counter==WIDTH-1), apply sign correction and load result, then go to END:
    - Quotient is negated if signed and the operand signs differ.
    - Remainder takes the sign of the dividend if signed.
- DIV_ZERO: on the next edge, result=64'h0 and go to END.
- END:
  - ready=1 and result is held.
  - Stay in END while start=1.
  - Go to IDLE on the first cycle with start=0; ready drops on that edge.
- Latency:
  - start first sampled high at edge E: ready is high in the cycle after edge E+33.
  - Divide-by-zero: ready is high after edge E+2.
- stall_req (combinational) = start & ~ready & ~annul.
- annul=1 in any state: next edge goes to IDLE with ready=0 and counter=0; result is held unchanged. annul has priority over start on the same edge.
- Operand changes while in ON or END are ignored; only the values latched at acceptance are used.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0 (two's-complement wrap, no trap).
- No back-to-back restart from END without start first dropping for at least 1 cycle.

Decomposition:
- Constants go in the shared headers:
  - DIV state encodings (DIV_IDLE, DIV_ZERO, DIV_ON, DIV_END) in defines.vh.
  - The existing ALU_SIGNED_DIV / ALU_UNSIGNED_DIV codes in aludefines.vh select signed_div upstream.
- No sub-module is warranted. The single-iteration subtract/shift stays inline.
- The execute-stage mux owns HI/LO writeback.

Test Plan:
- Unsigned divide:
  - Stimulus: DIVU opdata1=100, opdata2=7, start held until ready.
  - Required response: ready after 33 cycles; result={32'd2, 32'd14}; stall_req=1 every cycle before ready.
- Signed divide with mixed operand signs:
  - Stimulus: DIV -7 / 2.
  - Required response: quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1).
  - Stimulus: DIV 7 / -2.
  - Required response: quotient=-3, remainder=+1.
- Divide by zero:
  - Stimulus: opdata1=0x1234, opdata2=0.
  - Required response: ready 2 cycles after start; result=64'h0; then start=0 returns the FSM to IDLE.
- Signed overflow:
  - Stimulus: DIV 0x80000000 / 0xFFFFFFFF.
  - Required response: quotient=0x80000000, remainder=0; no hang.
- Annul and reset mid-operation:
  - Stimulus: annul pulse at iteration 10.
  - Required response: next cycle state=IDLE, ready=0, stall_req=0. A new start (50/5) afterwards gives {0, 10} after 33 cycles.
  - Stimulus: resetn=0 pulsed during ON.
  - Required response: outputs clear immediately, with no clock edge needed.
- END hold and re-arm:
  - Stimulus: start held high 5 cycles past ready, with operands changed meanwhile.
  - Required response: ready stays high and result is unchanged.
  - Stimulus: start dropped for 1 cycle, then raised again.
  - Required response: a new division begins.
